timer_counter_n: RTL and testbench

//  Parametrised timer/counter: one RTL block replaces the separate 8- and 16-bit timers.

---
 rtl/timer_counter_n_if.sv | 32 +++
 rtl/timer_counter_n.sv | 117 +++++++++++
 tb/tb_timer_counter_n.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/timer_counter_n_if.sv
// rtl/timer_counter_n_if.sv - I/O register bus bundle for timer_counter_n
interface timer_counter_n_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] TCNT_input;
  logic             TCNT_we;
  logic [WIDTH-1:0] OCR_input;
  logic             OCR_we;
  logic [7:0]       TCCR_input;
  logic             TCCR_we;
  logic [1:0]       TIMSK_input;
  logic             TIMSK_we;
  logic [1:0]       TIFR_input;
  logic             TIFR_we;
  logic [WIDTH-1:0] TCNT_output;
  logic [WIDTH-1:0] OCR_output;
  logic [7:0]       TCCR_output;
  logic [1:0]       TIMSK_output;
  logic [1:0]       TIFR_output;

  modport master (
    output TCNT_input, TCNT_we, OCR_input, OCR_we, TCCR_input, TCCR_we,
           TIMSK_input, TIMSK_we, TIFR_input, TIFR_we,
    input  TCNT_output, OCR_output, TCCR_output, TIMSK_output, TIFR_output
  );

  modport slave (
    input  TCNT_input, TCNT_we, OCR_input, OCR_we, TCCR_input, TCCR_we,
           TIMSK_input, TIMSK_we, TIFR_input, TIFR_we,
    output TCNT_output, OCR_output, TCCR_output, TIMSK_output, TIFR_output
  );
endinterface

// File: rtl/timer_counter_n.sv
// rtl/timer_counter_n.sv - parametrised timer/counter with prescaler, external clock, CTC and flags
module timer_counter_n #(
  parameter int WIDTH    = 8,
  parameter int EXT_SYNC = 2
) (
  input  logic               sysClock,
  input  logic               rst_n,
  timer_counter_n_if.slave   bus,
  input  logic               ack_ovf,
  input  logic               ack_cmp,
  input  logic               T_pin,
  output logic               irq_ovf,
  output logic               irq_cmp
);

  localparam logic [WIDTH-1:0] MAX = '1;

  logic [WIDTH-1:0]    tcnt_q, tcnt_d;
  logic [WIDTH-1:0]    ocr_q, ocr_d;
  logic [3:0]          tccr_q, tccr_d;   // reserved bits [7:4] are not stored
  logic [1:0]          timsk_q, timsk_d;
  logic                tov_q, tov_d;
  logic                ocf_q, ocf_d;
  logic [9:0]          pre_q, pre_d;
  logic [EXT_SYNC-1:0] sync_q, sync_d;
  logic                prev_q, prev_d;

  logic [2:0]  cs;
  logic        ctc;
  logic        sync_last;
  logic [EXT_SYNC:0] sync_chain;
  logic        tick;
  logic        set_ovf;
  logic        set_ocf;

  assign cs         = tccr_q[2:0];
  assign ctc        = tccr_q[3];
  assign sync_chain = {sync_q, T_pin};
  assign sync_last  = sync_q[EXT_SYNC-1];

  // Select the count tick from the prescaler taps or the synchronised pin edges
  always_comb begin
    tick = 1'b0;
    case (cs)
      3'd1:    tick = 1'b1;
      3'd2:    tick = &pre_q[2:0];
      3'd3:    tick = &pre_q[5:0];
      3'd4:    tick = &pre_q[7:0];
      3'd5:    tick = &pre_q[9:0];
      3'd6:    tick = prev_q & ~sync_last;
      3'd7:    tick = ~prev_q & sync_last;
      default: tick = 1'b0;
    endcase
  end

  // Next-state for counter, registers, flags and the input synchroniser
  always_comb begin
    tcnt_d  = tcnt_q;
    set_ovf = 1'b0;
    set_ocf = 1'b0;
    if (bus.TCNT_we) begin
      tcnt_d = bus.TCNT_input;
    end else if (tick) begin
      set_ocf = (tcnt_q == ocr_q);
      // Both modes reach 0 from MAX only by wrapping, so MAX alone decides TOV
      set_ovf = (tcnt_q == MAX);
      if (ctc && set_ocf) tcnt_d = '0;
      else                tcnt_d = tcnt_q + 1'b1;
    end

    ocr_d   = bus.OCR_we   ? bus.OCR_input        : ocr_q;
    tccr_d  = bus.TCCR_we  ? bus.TCCR_input[3:0]  : tccr_q;
    timsk_d = bus.TIMSK_we ? bus.TIMSK_input      : timsk_q;

    // A new event beats any clear arriving in the same cycle
    tov_d = set_ovf | (tov_q & ~(bus.TIFR_we & bus.TIFR_input[0]) & ~ack_ovf);
    ocf_d = set_ocf | (ocf_q & ~(bus.TIFR_we & bus.TIFR_input[1]) & ~ack_cmp);

    pre_d  = (cs == 3'd0) ? 10'd0 : pre_q + 10'd1;
    sync_d = sync_chain[EXT_SYNC-1:0];
    prev_d = sync_last;
  end

  // State registers, cleared asynchronously
  always_ff @(posedge sysClock or negedge rst_n) begin
    if (!rst_n) begin
      tcnt_q  <= '0;
      ocr_q   <= '0;
      tccr_q  <= '0;
      timsk_q <= '0;
      tov_q   <= 1'b0;
      ocf_q   <= 1'b0;
      pre_q   <= '0;
      sync_q  <= '0;
      prev_q  <= 1'b0;
    end else begin
      tcnt_q  <= tcnt_d;
      ocr_q   <= ocr_d;
      tccr_q  <= tccr_d;
      timsk_q <= timsk_d;
      tov_q   <= tov_d;
      ocf_q   <= ocf_d;
      pre_q   <= pre_d;
      sync_q  <= sync_d;
      prev_q  <= prev_d;
    end
  end

  assign bus.TCNT_output  = tcnt_q;
  assign bus.OCR_output   = ocr_q;
  assign bus.TCCR_output  = {4'b0000, tccr_q};
  assign bus.TIMSK_output = timsk_q;
  assign bus.TIFR_output  = {ocf_q, tov_q};
  assign irq_ovf          = tov_q & timsk_q[0];
  assign irq_cmp          = ocf_q & timsk_q[1];

endmodule

// File: tb/tb_timer_counter_n.sv
// tb/tb_timer_counter_n.sv - directed and randomized checks of timer_counter_n against a reference model
module tb_timer_counter_n;

  localparam int W    = 8;
  localparam int ES   = 2;
  localparam int MAXV = (1 << W) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ack_ovf = 1'b0;
  logic ack_cmp = 1'b0;
  logic T_pin = 1'b0;
  logic irq_ovf, irq_cmp;

  int tests = 0;
  int fails = 0;

  timer_counter_n_if #(.WIDTH(W)) bus ();

  timer_counter_n #(.WIDTH(W), .EXT_SYNC(ES)) dut (
    .sysClock (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .ack_ovf  (ack_ovf),
    .ack_cmp  (ack_cmp),
    .T_pin    (T_pin),
    .irq_ovf  (irq_ovf),
    .irq_cmp  (irq_cmp)
  );

  always #5 clk = ~clk;

  // Reference model state
  int m_tcnt, m_ocr, m_tccr, m_timsk, m_tov, m_ocf, m_pre;
  int h [0:ES];   // h[k] = pin value sampled k+1 clock edges ago

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_tcnt = 0; m_ocr = 0; m_tccr = 0; m_timsk = 0; m_tov = 0; m_ocf = 0; m_pre = 0;
    for (int k = 0; k <= ES; k++) h[k] = 0;
  endtask

  task automatic clear_pulses();
    bus.TCNT_we = 0; bus.OCR_we = 0; bus.TCCR_we = 0; bus.TIMSK_we = 0; bus.TIFR_we = 0;
    ack_ovf = 0; ack_cmp = 0;
  endtask

  task automatic check_all(input string tag);
    chk({tag, "_tcnt"},  bus.TCNT_output,  m_tcnt);
    chk({tag, "_ocr"},   bus.OCR_output,   m_ocr);
    chk({tag, "_tccr"},  bus.TCCR_output,  m_tccr);
    chk({tag, "_timsk"}, bus.TIMSK_output, m_timsk);
    chk({tag, "_tifr"},  bus.TIFR_output,  m_ocf * 2 + m_tov);
    chk({tag, "_irqo"},  irq_ovf, (m_tov != 0 && (m_timsk & 1) != 0) ? 1 : 0);
    chk({tag, "_irqc"},  irq_cmp, (m_ocf != 0 && (m_timsk & 2) != 0) ? 1 : 0);
  endtask

  // One clock: predict from the rules, let the edge pass, then compare everything
  task automatic cycle(input string tag);
    int cs, ctc, tk, n_tcnt, n_tov, n_ocf, so, sc, n_pre;
    cs  = m_tccr % 8;
    ctc = (m_tccr / 8) % 2;
    case (cs)
      1: tk = 1;
      2: tk = (m_pre % 8    == 7)    ? 1 : 0;
      3: tk = (m_pre % 64   == 63)   ? 1 : 0;
      4: tk = (m_pre % 256  == 255)  ? 1 : 0;
      5: tk = (m_pre % 1024 == 1023) ? 1 : 0;
      6: tk = (h[ES-1] == 0 && h[ES] == 1) ? 1 : 0;
      7: tk = (h[ES-1] == 1 && h[ES] == 0) ? 1 : 0;
      default: tk = 0;
    endcase
    n_tcnt = m_tcnt; so = 0; sc = 0;
    if (bus.TCNT_we) n_tcnt = int'(bus.TCNT_input);
    else if (tk != 0) begin
      sc = (m_tcnt == m_ocr) ? 1 : 0;
      so = (m_tcnt == MAXV) ? 1 : 0;
      n_tcnt = (ctc != 0 && sc != 0) ? 0 : (m_tcnt + 1) % (MAXV + 1);
    end
    n_tov = so != 0 ? 1 : (((bus.TIFR_we && bus.TIFR_input[0]) || ack_ovf) ? 0 : m_tov);
    n_ocf = sc != 0 ? 1 : (((bus.TIFR_we && bus.TIFR_input[1]) || ack_cmp) ? 0 : m_ocf);
    n_pre = (cs == 0) ? 0 : (m_pre + 1) % 1024;
    @(posedge clk);
    #1;
    for (int k = ES; k > 0; k--) h[k] = h[k-1];
    h[0] = T_pin ? 1 : 0;
    if (bus.OCR_we)   m_ocr   = int'(bus.OCR_input);
    if (bus.TCCR_we)  m_tccr  = int'(bus.TCCR_input) % 16;
    if (bus.TIMSK_we) m_timsk = int'(bus.TIMSK_input);
    m_tcnt = n_tcnt; m_tov = n_tov; m_ocf = n_ocf; m_pre = n_pre;
    clear_pulses();
    check_all(tag);
  endtask

  task automatic wr_stop(input int tcnt, input int ocr);
    bus.TCCR_input = 8'h00; bus.TCCR_we = 1;
    bus.TCNT_input = W'(tcnt); bus.TCNT_we = 1;
    bus.OCR_input = W'(ocr); bus.OCR_we = 1;
    bus.TIFR_input = 2'b11; bus.TIFR_we = 1;
    cycle("setup");
  endtask

  initial begin
    bus.TCNT_input = '0; bus.OCR_input = '0; bus.TCCR_input = '0;
    bus.TIMSK_input = '0; bus.TIFR_input = '0;
    clear_pulses();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    rst_n = 1'b1;

    // 1: normal mode overflow and W1C of TOV
    bus.TCNT_input = 8'hFD; bus.TCNT_we = 1;
    bus.TCCR_input = 8'h01; bus.TCCR_we = 1;
    bus.TIMSK_input = 2'b01; bus.TIMSK_we = 1;
    cycle("t1_load");
    cycle("t1"); chk("t1_fe", bus.TCNT_output, 8'hFE);
    cycle("t1"); chk("t1_ff", bus.TCNT_output, 8'hFF);
    cycle("t1"); chk("t1_00", bus.TCNT_output, 8'h00);
    chk("t1_tov", bus.TIFR_output[0], 1'b1);
    chk("t1_irq", irq_ovf, 1'b1);
    bus.TIFR_input = 2'b01; bus.TIFR_we = 1;
    cycle("t1_clr");
    chk("t1_tov_clr", bus.TIFR_output[0], 1'b0);
    chk("t1_irq_clr", irq_ovf, 1'b0);

    // 2: CTC with /8 prescaler, OCR=3
    wr_stop(0, 3);
    bus.TCCR_input = 8'h0A; bus.TCCR_we = 1;
    cycle("t2_go");
    for (int i = 1; i <= 32; i++) begin
      cycle("t2");
      if (i % 8 == 0) chk("t2_step", bus.TCNT_output, (i / 8) % 4);
    end
    chk("t2_ocf", bus.TIFR_output[1], 1'b1);
    repeat (32) cycle("t2b");
    chk("t2_no_tov", bus.TIFR_output[0], 1'b0);

    // 3: external rising edges, 3-clock latency, falling edges ignored
    wr_stop(0, 8'hFF);
    bus.TCCR_input = 8'h07; bus.TCCR_we = 1;
    cycle("t3_go");
    for (int i = 0; i < 5; i++) begin
      T_pin = 1'b1;
      cycle("t3"); cycle("t3");
      chk("t3_wait", bus.TCNT_output, i);
      cycle("t3");
      chk("t3_inc", bus.TCNT_output, i + 1);
      T_pin = 1'b0;
      repeat (4) cycle("t3");
      chk("t3_fall", bus.TCNT_output, i + 1);
    end

    // 4: set beats W1C, ack clears
    wr_stop(8'h10, 8'h10);
    bus.TIMSK_input = 2'b11; bus.TIMSK_we = 1;
    bus.TCCR_input = 8'h01; bus.TCCR_we = 1;
    cycle("t4_go");
    bus.TIFR_input = 2'b10; bus.TIFR_we = 1;
    cycle("t4_set");
    chk("t4_ocf_kept", bus.TIFR_output[1], 1'b1);
    chk("t4_irq", irq_cmp, 1'b1);
    ack_cmp = 1'b1;
    cycle("t4_ack");
    chk("t4_ocf_ack", bus.TIFR_output[1], 1'b0);
    chk("t4_irq_ack", irq_cmp, 1'b0);

    // 5: TCNT load beats a matching tick
    wr_stop(8'h20, 8'h20);
    bus.TCCR_input = 8'h01; bus.TCCR_we = 1;
    cycle("t5_go");
    bus.TCNT_input = 8'h40; bus.TCNT_we = 1;
    bus.OCR_input = 8'h40; bus.OCR_we = 1;
    cycle("t5_ld");
    chk("t5_tcnt", bus.TCNT_output, 8'h40);
    chk("t5_no_ocf", bus.TIFR_output[1], 1'b0);
    cycle("t5_nx");
    chk("t5_ocf", bus.TIFR_output[1], 1'b1);

    // 6: asynchronous reset mid-count
    bus.TCNT_input = 8'h7F; bus.TCNT_we = 1;
    bus.TCCR_input = 8'h03; bus.TCCR_we = 1;
    cycle("t6_go");
    repeat (70) cycle("t6");
    #3 rst_n = 1'b0;
    #1;
    model_reset();
    check_all("t6_arst");
    chk("t6_tcnt0", bus.TCNT_output, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) cycle("t6_hold");
    chk("t6_held", bus.TCNT_output, 0);

    // Randomized traffic against the model
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(15) == 0) begin bus.TCNT_input = W'($urandom); bus.TCNT_we = 1; end
      if ($urandom_range(15) == 0) begin bus.OCR_input = W'($urandom); bus.OCR_we = 1; end
      if ($urandom_range(47) == 0) begin bus.TCCR_input = 8'($urandom); bus.TCCR_we = 1; end
      if ($urandom_range(15) == 0) begin bus.TIMSK_input = 2'($urandom); bus.TIMSK_we = 1; end
      if ($urandom_range(7) == 0) begin bus.TIFR_input = 2'($urandom); bus.TIFR_we = 1; end
      ack_ovf = ($urandom_range(9) == 0);
      ack_cmp = ($urandom_range(9) == 0);
      if ($urandom_range(3) == 0) T_pin = ~T_pin;
      cycle("rnd");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
